// File: rtl/compare_pkg.sv
// -----------------------------------------------------------------------------
// compare_pkg
// Shared types and constants for the sequential magnitude comparator.
//   state_e     : controller states (IDLE, RUN)
//   cmp_res_t   : 3-bit one-hot compare result, bit order {x, y, z} = {gt, eq, lt}
//   CMP_*       : result encodings
//   num_digits(): number of DIGIT-wide slices in a WIDTH-bit operand
// -----------------------------------------------------------------------------
package compare_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_GT   = 3'b100;
  localparam cmp_res_t CMP_EQ   = 3'b010;
  localparam cmp_res_t CMP_LT   = 3'b001;
  localparam cmp_res_t CMP_NONE = 3'b000;

  // WIDTH is expected to be an exact multiple of DIGIT.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage : compare_pkg

// File: rtl/digit_compare.sv
// -----------------------------------------------------------------------------
// digit_compare
// Combinational unsigned compare of one DIGIT-wide slice. Exactly one of the
// three outputs is high for any input pair.
// Ports:
//   a_i  in  DIGIT  slice of operand A
//   b_i  in  DIGIT  slice of operand B
//   gt_o out 1      a_i >  b_i
//   eq_o out 1      a_i == b_i
//   lt_o out 1      a_i <  b_i
// -----------------------------------------------------------------------------
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  assign gt_o = (a_i >  b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i <  b_i);

endmodule : digit_compare

// File: rtl/seq_compare.sv
// -----------------------------------------------------------------------------
// seq_compare
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared one
// DIGIT-bit slice per clock, most significant slice first, in either unsigned
// or two's complement mode. A start/done handshake launches an operation; the
// one-hot result {x, y, z} is registered and holds until the next completion.
//
// Ports:
//   clk          in  1      system clock, rising edge
//   rst          in  1      synchronous active-high reset
//   start        in  1      request a compare (sampled only in IDLE)
//   signed_mode  in  1      1 = two's complement, 0 = unsigned (latched with start)
//   a            in  WIDTH  operand A (latched with start)
//   b            in  WIDTH  operand B (latched with start)
//   busy         out 1      operation in progress
//   done         out 1      one-cycle pulse, result valid
//   x            out 1      A >  B
//   y            out 1      A == B
//   z            out 1      A <  B
//
// Build option:
//   SEQ_COMPARE_EARLY_EXIT_EN - when defined, the operation completes as soon
//   as a slice differs (latency 1..NUM_DIGITS). When undefined, latency is
//   always NUM_DIGITS cycles. Results are identical in both builds.
// -----------------------------------------------------------------------------
module seq_compare
  import compare_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             x,
  output logic             y,
  output logic             z
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  // ---------------------------------------------------------------------------
  // Latched operands, stored as arrays of slices so the slice mux is a plain
  // array index.
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][DIGIT-1:0] a_q;
  logic [NUM_DIGITS-1:0][DIGIT-1:0] b_q;
  logic                             signed_q;

  // Controller state and registered outputs
  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             decided_q;
  cmp_res_t         res_q;
  cmp_res_t         xyz_q;
  logic             busy_q;
  logic             done_q;

  // Per-cycle slice evaluation
  logic [DIGIT-1:0] a_slice;
  logic [DIGIT-1:0] b_slice;
  logic             dc_gt;
  logic             dc_eq;
  logic             dc_lt;
  cmp_res_t         slice_res;
  cmp_res_t         result_d;
  logic             decided_d;
  logic             finish_d;
  logic             sign_differs;

  wire launch = (state_q == IDLE) && start;

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  // NOTE: pure datapath registers carry no reset; they are only read in RUN,
  // which is always entered through a capture, so a reset value would never be
  // observed.
  always_ff @(posedge clk) begin
    if (launch) begin
      a_q      <= a;
      b_q      <= b;
      signed_q <= signed_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Slice mux and shared compare cell
  // ---------------------------------------------------------------------------
  assign a_slice = a_q[idx_q];
  assign b_slice = b_q[idx_q];

  digit_compare #(
    .DIGIT (DIGIT)
  ) u_digit_compare (
    .a_i  (a_slice),
    .b_i  (b_slice),
    .gt_o (dc_gt),
    .eq_o (dc_eq),
    .lt_o (dc_lt)
  );

  assign sign_differs = a_q[NUM_DIGITS-1][DIGIT-1] ^ b_q[NUM_DIGITS-1][DIGIT-1];

  // ---------------------------------------------------------------------------
  // Slice decision
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a value before any condition, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    slice_res = {dc_gt, dc_eq, dc_lt};

    // In the top slice of a signed compare, differing sign bits decide the
    // result on their own: the operand with sign bit 0 is the larger one.
    // The unsigned slice compare would give the opposite answer there.
    if ((idx_q == TOP_IDX) && signed_q && sign_differs) begin
      slice_res = a_q[NUM_DIGITS-1][DIGIT-1] ? CMP_LT : CMP_GT;
    end

    // The first differing slice wins; later slices never overwrite it.
    result_d  = decided_q ? res_q : slice_res;
    decided_d = decided_q | (slice_res != CMP_EQ);

`ifdef SEQ_COMPARE_EARLY_EXIT_EN
    finish_d = (idx_q == '0) || (slice_res != CMP_EQ);
`else
    finish_d = (idx_q == '0);
`endif
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others; a later assignment in
  // the same block simply overrides the default given above it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      decided_q <= 1'b0;
      res_q     <= CMP_NONE;
      xyz_q     <= CMP_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            idx_q     <= TOP_IDX;
            decided_q <= 1'b0;
          end
        end

        RUN: begin
          res_q     <= result_d;
          decided_q <= decided_d;
          if (finish_d) begin
            // Reaching the last slice undecided means every slice matched,
            // and result_d already carries CMP_EQ in that case.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            xyz_q   <= result_d;
          end else begin
            idx_q <= idx_q - IDX_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign {x, y, z} = xyz_q;

endmodule : seq_compare

// File: tb/tb_seq_compare.sv
// -----------------------------------------------------------------------------
// tb_seq_compare
// Self-checking bench for seq_compare (WIDTH=16, DIGIT=4). Expected results
// come from integer arithmetic on the operands; expected latency comes from
// locating the first differing slice. Honours SEQ_COMPARE_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
module tb_seq_compare;

  localparam int WIDTH   = 16;
  localparam int DIGIT   = 4;
  localparam int ND      = WIDTH / DIGIT;
  localparam int TIMEOUT = 20;

  localparam logic [2:0] R_GT   = 3'b100;
  localparam logic [2:0] R_EQ   = 3'b010;
  localparam logic [2:0] R_LT   = 3'b001;
  localparam logic [2:0] R_NONE = 3'b000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             x;
  logic             y;
  logic             z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_compare #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .x           (x),
    .y           (y),
    .z           (z)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] ai,
                                           input logic [WIDTH-1:0] bi,
                                           input logic si);
    longint va;
    longint vb;
    if (si) begin
      va = longint'($signed(ai));
      vb = longint'($signed(bi));
    end else begin
      va = longint'({48'd0, ai});
      vb = longint'({48'd0, bi});
    end
    if (va > vb)  return R_GT;
    if (va == vb) return R_EQ;
    return R_LT;
  endfunction

  // Cycles from the start-sampling edge to the edge that raises done.
  function automatic int model_lat(input logic [WIDTH-1:0] ai,
                                   input logic [WIDTH-1:0] bi);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
    int mask;
    mask = (1 << DIGIT) - 1;
    for (int k = 1; k <= ND; k++) begin
      if (((int'(ai) >> (DIGIT * (ND - k))) & mask) !=
          ((int'(bi) >> (DIGIT * (ND - k))) & mask))
        return k;
    end
    return ND;
`else
    return ND + 0 * int'(ai ^ bi);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Run one operation. Checks busy on every waiting cycle; returns the
  // observed latency (-1 on timeout) and the result seen with done.
  // With noise set, inputs (including start) are scrambled while RUN.
  // ---------------------------------------------------------------------------
  task automatic do_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                       input logic si, input bit noise,
                       output int lat, output logic [2:0] res);
    lat = -1;
    res = R_NONE;
    @(negedge clk);
    a = ai; b = bi; signed_mode = si; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL op_first_cycle: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        res = {x, y, z};
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL op_busy_at_done: busy=%b, required 0", busy);
        end
        break;
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL op_busy_in_run: cycle %0d busy=%b, required 1", c, busy);
      end
      if (noise) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        signed_mode = 1'($urandom);
        start = 1'($urandom);
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL op_timeout: no done within %0d cycles for a=%h b=%h", TIMEOUT, ai, bi);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; signed_mode = 1'b0; a = 16'h1234; b = 16'h0001;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, x, y, z} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy,done,x,y,z=%b, required 00000", {busy, done, x, y, z});
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_after_release: busy=%b, required 0", busy);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [2:0]       exp;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[6];
    int lat;
    logic [2:0] res;
    vecs[0] = '{16'h1234, 16'h1234, 1'b0, R_EQ};
    vecs[1] = '{16'h8000, 16'h0001, 1'b1, R_LT};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, R_GT};
    vecs[3] = '{16'hFFFE, 16'hFFFF, 1'b1, R_LT};
    vecs[4] = '{16'hF000, 16'h0FFF, 1'b0, R_GT};
    vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, R_GT};
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, lat, res);
      n_checks++;
      if (res !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: a=%h b=%h s=%b xyz=%b, required %b",
                 i, vecs[i].a, vecs[i].b, vecs[i].s, res, vecs[i].exp);
      end
      n_checks++;
      if (lat != model_lat(vecs[i].a, vecs[i].b)) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, required %0d",
                 i, lat, model_lat(vecs[i].a, vecs[i].b));
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [2:0] res;
    logic [WIDTH-1:0] ra, rb;
    logic rs;
    int sl;
    for (int n = 0; n < 300; n++) begin
      ra = WIDTH'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(0, 2))
        0: rb = WIDTH'($urandom);
        1: rb = ra;
        default: begin
          sl = $urandom_range(0, ND - 1);
          rb = ra;
          rb[sl*DIGIT +: DIGIT] = DIGIT'($urandom);
        end
      endcase
      do_op(ra, rb, rs, 1'b1, lat, res);
      n_checks++;
      if (res !== model_res(ra, rb, rs)) begin
        n_fail++;
        $display("FAIL random_result: a=%h b=%h s=%b xyz=%b, required %b",
                 ra, rb, rs, res, model_res(ra, rb, rs));
      end
      n_checks++;
      if (lat != model_lat(ra, rb)) begin
        n_fail++;
        $display("FAIL random_latency: a=%h b=%h got %0d, required %0d",
                 ra, rb, lat, model_lat(ra, rb));
      end
    end
  endtask

  task automatic test_handshake();
    int dones = 0;
    int lat = -1;
    // Unsigned 5 vs 9; 4 -> lat equals ND in both builds only if top slices
    // match, which they do here (decided in the last slice).
    @(negedge clk);
    a = 16'd5; b = 16'd9; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < ND; c++) begin
      if (done === 1'b1) dones++;
      if (c == 1) begin
        start = 1'b1; a = 16'd9; b = 16'd5; signed_mode = 1'b1;
      end else begin
        start = 1'b0; a = 16'hFFFF; b = 16'h0000;
      end
      @(negedge clk);
    end
    // Now in the done cycle.
    n_checks++;
    if (done !== 1'b1 || dones != 0 || {x, y, z} !== R_LT) begin
      n_fail++;
      $display("FAIL handshake_first: done=%b early_dones=%0d xyz=%b, required done=1 early_dones=0 xyz=%b",
               done, dones, {x, y, z}, R_LT);
    end
    // start in the done cycle must be accepted.
    start = 1'b1; a = 16'h00FF; b = 16'h00FF; signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || {x, y, z} !== R_LT) begin
      n_fail++;
      $display("FAIL handshake_accept: busy=%b xyz=%b, required busy=1 xyz=%b", busy, {x, y, z}, R_LT);
    end
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    n_checks++;
    if (lat != ND || {x, y, z} !== R_EQ) begin
      n_fail++;
      $display("FAIL handshake_second: latency=%0d xyz=%b, required latency=%0d xyz=%b",
               lat, {x, y, z}, ND, R_EQ);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat;
    logic [2:0] res;
    @(negedge clk);
    a = 16'h1234; b = 16'h1235; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, x, y, z} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy,done,x,y,z=%b, required 00000", {busy, done, x, y, z});
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: %0d done pulses, required 0", dones);
    end
    do_op(16'h0000, 16'h0000, 1'b0, 1'b0, lat, res);
    n_checks++;
    if (res !== R_EQ || lat != ND) begin
      n_fail++;
      $display("FAIL reset_mid_restart: xyz=%b latency=%0d, required %b latency=%0d",
               res, lat, R_EQ, ND);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_handshake();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_compare
